// File: rtl/hall_sensor_emulator.sv
// Emulates a rotating BLDC rotor's 3-bit Hall pattern at a programmable step rate and direction, with invalid-code injection.
// Latency: outputs are registered; the first change appears P cycles after enable rises, and every state then lasts P cycles.
// Backpressure: none; enable low freezes the pattern and holds the step counter at zero, keeping any armed fault.
module hall_sensor_emulator #(
   parameter int CNT_W      = 32,
   parameter int MIN_PERIOD = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             direction,
   input  logic [CNT_W-1:0] step_period,
   input  logic             period_wr,
   input  logic             fault_inject,
   output logic [2:0]       hall_out,
   output logic [2:0]       hall_index,
   output logic             edge_pulse,
   output logic             rev_pulse,
   output logic             fault_active,
   output logic [15:0]      step_count
);

   typedef enum logic {ST_NORMAL, ST_FAULT} state_t;

   localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PERIOD);

   state_t           state;
   logic [CNT_W-1:0] shadow_period;
   logic [CNT_W-1:0] active_period;
   logic [CNT_W-1:0] eff_period;
   logic [CNT_W-1:0] cnt;
   logic             fault_arm;
   logic             boundary;
   logic             inject_ok;
   logic [2:0]       next_index;
   logic             wrap;

   // Valid Hall code for each sequence index; one bit flips per step.
   function automatic logic [2:0] hall_code(input logic [2:0] idx);
      case (idx)
         3'd0:    hall_code = 3'b011;
         3'd1:    hall_code = 3'b010;
         3'd2:    hall_code = 3'b110;
         3'd3:    hall_code = 3'b100;
         3'd4:    hall_code = 3'b101;
         3'd5:    hall_code = 3'b001;
         default: hall_code = 3'b011;
      endcase
   endfunction

   // Clamp the period, detect the state boundary and pick the neighbouring index in the sampled direction.
   always_comb begin
      eff_period = (active_period < MIN_P) ? MIN_P : active_period;
      boundary   = enable && (cnt == eff_period - CNT_W'(1));
      inject_ok  = fault_inject && (state == ST_NORMAL);
      wrap       = 1'b0;
      next_index = hall_index;
      if (direction) begin
         wrap       = (hall_index == 3'd0);
         next_index = wrap ? 3'd5 : hall_index - 3'd1;
      end else begin
         wrap       = (hall_index == 3'd5);
         next_index = wrap ? 3'd0 : hall_index + 3'd1;
      end
   end

   // Period registers, step counter and the NORMAL/FAULT state machine with all registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_NORMAL;
         shadow_period <= MIN_P;
         active_period <= MIN_P;
         cnt           <= '0;
         fault_arm     <= 1'b0;
         hall_out      <= 3'b011;
         hall_index    <= 3'd0;
         step_count    <= 16'd0;
         edge_pulse    <= 1'b0;
         rev_pulse     <= 1'b0;
         fault_active  <= 1'b0;
      end else begin
         edge_pulse <= 1'b0;
         rev_pulse  <= 1'b0;

         if (period_wr)
            shadow_period <= step_period;

         if (!enable || boundary)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);

         // A fault consumed at this boundary may be re-armed by a coincident pulse.
         if (boundary && state == ST_NORMAL && fault_arm)
            fault_arm <= inject_ok;
         else if (inject_ok)
            fault_arm <= 1'b1;

         if (boundary) begin
            active_period <= shadow_period;
            if (state == ST_NORMAL && fault_arm) begin
               // Invalid code for one period; index and step count stay put.
               hall_out     <= 3'b000;
               fault_active <= 1'b1;
               edge_pulse   <= 1'b1;
               state        <= ST_FAULT;
            end else begin
               hall_index   <= next_index;
               hall_out     <= hall_code(next_index);
               step_count   <= step_count + 16'd1;
               edge_pulse   <= 1'b1;
               rev_pulse    <= wrap;
               fault_active <= 1'b0;
               state        <= ST_NORMAL;
            end
         end
      end
   end

endmodule
